// File: rtl/n8_controller_reader.sv
// rtl/n8_controller_reader.sv - N8 controller serial poller with parallel active-high button outputs
module n8_controller_reader #(
    parameter int PULSE_CYCLES = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       n8_data,
    output logic       n8_latch,
    output logic       n8_pulse,
    output logic [7:0] buttons,
    output logic       n8_a,
    output logic       n8_b,
    output logic       n8_select,
    output logic       n8_start,
    output logic       n8_up,
    output logic       n8_down,
    output logic       n8_left,
    output logic       n8_right,
    output logic       frame_valid
);
    localparam int PHASE_W = $clog2(2 * PULSE_CYCLES);
    localparam int POLL_W  = $clog2(POLL_CYCLES);
    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * PULSE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(PULSE_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        UPDATE
    } state_t;

    state_t               state, state_d;
    logic [1:0]           data_sync;
    logic [POLL_W-1:0]    poll_cnt;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift_q, shift_d;
    logic                 tick;
    logic                 phase_done;

    assign tick = (poll_cnt == POLL_LAST);

    // Idle level of the pull-up, so a reset never looks like a pressed button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], n8_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        phase_done = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_d = LATCH;
            end
            LATCH: begin
                phase_done = (phase_cnt == LATCH_LAST);
                if (phase_done) state_d = LOW;
            end
            LOW: begin
                phase_done = (phase_cnt == PULSE_LAST);
                if (phase_done) begin
                    shift_d[bit_idx] = ~data_sync[1];
                    state_d          = (bit_idx == 3'd7) ? UPDATE : HIGH;
                end
            end
            HIGH: begin
                phase_done = (phase_cnt == PULSE_LAST);
                if (phase_done) state_d = LOW;
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so they are glitch-free
    // yet still line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            buttons     <= '0;
            n8_latch    <= 1'b0;
            n8_pulse    <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state     <= state_d;
            shift_q   <= shift_d;
            phase_cnt <= (state_d != state || state == IDLE) ? '0 : phase_cnt + 1'b1;
            if (state == LATCH) begin
                bit_idx <= '0;
            end else if (state == HIGH && phase_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
            // Last bit is merged in here so buttons is current while frame_valid is high
            if (state_d == UPDATE) begin
                buttons <= shift_d;
            end
            n8_latch    <= (state_d == LATCH);
            n8_pulse    <= (state_d == HIGH);
            frame_valid <= (state_d == UPDATE);
        end
    end

    assign n8_a      = buttons[0];
    assign n8_b      = buttons[1];
    assign n8_select = buttons[2];
    assign n8_start  = buttons[3];
    assign n8_up     = buttons[4];
    assign n8_down   = buttons[5];
    assign n8_left   = buttons[6];
    assign n8_right  = buttons[7];

endmodule

// File: tb/tb_n8_controller_reader.sv
// tb/tb_n8_controller_reader.sv - randomized bench for n8_controller_reader against a frame-schedule model
module tb_n8_controller_reader;
    localparam int P      = 4;
    localparam int FL     = 17 * P;
    localparam int POLL_A = 100;
    localparam int POLL_B = 60;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2];
    logic       data_w  [2];
    logic       latch_w [2];
    logic       pulse_w [2];
    logic       fv_w    [2];
    logic [7:0] btn_w   [2];
    logic [7:0] alias_w [2];

    logic [7:0] pat  [2];
    int         mode [2];

    int checks = 0;
    int errors = 0;

    n8_controller_reader #(.PULSE_CYCLES(P), .POLL_CYCLES(POLL_A)) dut_a (
        .clk(clk), .reset_n(rst_n[0]), .n8_data(data_w[0]),
        .n8_latch(latch_w[0]), .n8_pulse(pulse_w[0]), .buttons(btn_w[0]),
        .n8_a(alias_w[0][0]), .n8_b(alias_w[0][1]), .n8_select(alias_w[0][2]), .n8_start(alias_w[0][3]),
        .n8_up(alias_w[0][4]), .n8_down(alias_w[0][5]), .n8_left(alias_w[0][6]), .n8_right(alias_w[0][7]),
        .frame_valid(fv_w[0])
    );

    n8_controller_reader #(.PULSE_CYCLES(P), .POLL_CYCLES(POLL_B)) dut_b (
        .clk(clk), .reset_n(rst_n[1]), .n8_data(data_w[1]),
        .n8_latch(latch_w[1]), .n8_pulse(pulse_w[1]), .buttons(btn_w[1]),
        .n8_a(alias_w[1][0]), .n8_b(alias_w[1][1]), .n8_select(alias_w[1][2]), .n8_start(alias_w[1][3]),
        .n8_up(alias_w[1][4]), .n8_down(alias_w[1][5]), .n8_left(alias_w[1][6]), .n8_right(alias_w[1][7]),
        .frame_valid(fv_w[1])
    );

    // Controller: parallel load while latched, shift toward bit 0 on pulse rise, pull-up fills in
    for (genvar g = 0; g < 2; g++) begin : g_ctl
        logic [7:0] sr = 8'hFF;
        always @(posedge latch_w[g] or posedge pulse_w[g]) begin
            if (latch_w[g]) sr <= pat[g];
            else            sr <= {1'b1, sr[7:1]};
        end
        assign data_w[g] = (mode[g] == 1) ? 1'b1 : (mode[g] == 2) ? 1'b0 : sr[0];
    end

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pressed(input int i);
        if (mode[i] == 1) return 8'h00;
        if (mode[i] == 2) return 8'hFF;
        return ~pat[i];
    endfunction

    // Model: k = clk edges since reset release; a frame's first latch cycle is fs
    int         k    [2] = '{0, 0};
    int         fs   [2] = '{-1, -1};
    logic [7:0] fexp [2] = '{8'h00, 8'h00};
    logic [7:0] ebtn [2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int poll;
            int f;
            bit inf;
            poll = (i == 0) ? POLL_A : POLL_B;
            if (!rst_n[i]) begin
                k[i]    = 0;
                fs[i]   = -1;
                ebtn[i] = 8'h00;
            end else begin
                k[i]++;
            end
            f   = k[i] - fs[i];
            inf = rst_n[i] && fs[i] >= 0 && f >= 0 && f <= FL;
            if (inf && f == FL) ebtn[i] = fexp[i];
            chk("latch", i, latch_w[i], inf && f < 2 * P);
            chk("pulse", i, pulse_w[i], inf && f >= 2 * P && f < 16 * P && ((f - 2 * P) / P) % 2 == 1);
            chk("frame_valid", i, fv_w[i], inf && f == FL);
            chk("buttons", i, btn_w[i], ebtn[i]);
            chk("aliases", i, alias_w[i], ebtn[i]);
            if (rst_n[i] && k[i] % poll == poll - 1 && !inf) begin
                fs[i]   = k[i] + 1;
                fexp[i] = pressed(i);
            end
        end
    end

    task automatic wait_fv(input int i, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (fv_w[i] === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_fv dut%0d: no frame_valid within %0d cycles", i, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        pat[0]   = 8'hF7;
        pat[1]   = 8'($urandom);
        mode[0]  = 0;
        mode[1]  = 0;
        repeat (3) @(negedge clk);
        #2;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        fork
            begin : seq_a
                int n;
                wait_fv(0, 400, n);
                lit("first_fv_cycle", n, 168);
                lit("btn_start", btn_w[0], 8'h08);
                lit("n8_start", alias_w[0][3], 1);
                repeat (45) @(negedge clk);
                #2;
                lit("pulse_before_reset", pulse_w[0], 1);
                rst_n[0] = 1'b0;
                #1;
                lit("rst_latch", latch_w[0], 0);
                lit("rst_pulse", pulse_w[0], 0);
                lit("rst_buttons", btn_w[0], 0);
                lit("rst_fv", fv_w[0], 0);
                pat[0] = ~8'h50;
                repeat (3) @(negedge clk);
                #2;
                rst_n[0] = 1'b1;
                wait_fv(0, 400, n);
                lit("restart_fv_cycle", n, 168);
                lit("btn_left_up", btn_w[0], 8'h50);
                lit("n8_left", alias_w[0][6], 1);
                lit("n8_up", alias_w[0][4], 1);
                pat[0] = 8'hFF;
                wait_fv(0, 150, n);
                lit("spacing_release", n, 100);
                lit("btn_release", btn_w[0], 8'h00);
                mode[0] = 1;
                wait_fv(0, 150, n);
                lit("btn_stuck_high", btn_w[0], 8'h00);
                mode[0] = 2;
                wait_fv(0, 150, n);
                lit("btn_stuck_low", btn_w[0], 8'hFF);
                mode[0] = 0;
                repeat (5) begin
                    pat[0] = 8'($urandom);
                    wait_fv(0, 150, n);
                    lit("fv_spacing", n, 100);
                end
            end
            begin : seq_b
                int n1;
                wait_fv(1, 400, n1);
                lit("b_first_fv_cycle", n1, 128);
                repeat (6) begin
                    pat[1] = 8'($urandom);
                    wait_fv(1, 200, n1);
                    lit("b_fv_spacing", n1, 120);
                end
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/n8_controller_reader.md
# n8_controller_reader

Drives the serial latch/pulse/data protocol of the N8 (NES-style) game controller and turns its 8-bit shift-register output into parallel, active-high, level button signals. Sits at the board pins, upstream of `input_controller`, which consumes `n8_left/right/up/down/start`. Polls at a fixed frame rate and holds outputs stable between polls.

## Interface
Parameters:
- `PULSE_CYCLES`, default 300: length in clk cycles of one pulse half-phase, P; 6 µs at 50 MHz. Latch high lasts 2·P. Minimum 4.
- `POLL_CYCLES`, default 833333: poll period in clk cycles; 60 Hz at 50 MHz. Must be ≥ 17·P + 2.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `n8_data`  in  1  serial data from controller; active-low (0 = pressed), idles high via pull-up; asynchronous to clk
- `n8_latch`  out  1  latch strobe to controller, active high
- `n8_pulse`  out  1  shift clock to controller, active high
- `buttons`  out  8  registered button state, 1 = pressed; [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right
- `n8_a`, `n8_b`, `n8_select`, `n8_start`, `n8_up`, `n8_down`, `n8_left`, `n8_right`  out  1 each  aliases of the matching `buttons` bits
- `frame_valid`  out  1  one-cycle strobe in the cycle `buttons` updates

## Operation
- `n8_data` passes through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
- Poll timer: free-running counter 0..POLL_CYCLES-1, wraps to 0; a tick occurs on the wrap cycle. Tick in IDLE starts a frame; tick outside IDLE is dropped, and the counter keeps running.
- FSM states:
  - IDLE: latch=0, pulse=0. On tick, go to LATCH.
  - LATCH: latch=1 for 2·P cycles, then go to LOW with bit index 0.
  - LOW: latch=0, pulse=0 for P cycles. On the last cycle, sample inverted synchronized data into shift bit[index]. If index=7, go to UPDATE; otherwise go to HIGH.
  - HIGH: pulse=1 for P cycles, then increment index and go to LOW.
  - UPDATE: one cycle. Copy shift register to `buttons`, assert `frame_valid`, then go to IDLE.
- Bit order is the controller shift order: A first, Right last.
- `buttons` changes only in UPDATE; it holds the previous frame's value at all other times. No debounce and no edge detection; `input_controller` handles edges.
- Disconnected controller (data stuck high) gives buttons = 8'h00. Data stuck low gives 8'hFF.

## Timing
- Reset (async assert, any state including mid-frame): latch=0, pulse=0, buttons=0, all aliases 0, frame_valid=0, FSM=IDLE, poll counter=0, index=0, shift=0, synchronizer=1. Reset release is synchronous to clk.
- First tick occurs POLL_CYCLES-1 cycles after the first clk edge following release. Latch rises on the next cycle.
- Frame length, from latch rise to end of the last LOW: 2P + 8P + 7P = 17P cycles, then 1 UPDATE cycle. `frame_valid` appears 17P cycles after latch rises.
- Pulses: 7 per frame, each exactly P cycles high, with P cycles low between.
- Sampling happens ≥ P-1 cycles after the preceding edge, so the 2-cycle synchronizer latency is absorbed for P ≥ 4.
- Consecutive `frame_valid` pulses are exactly POLL_CYCLES apart.

## Test plan
Bench uses P=4 and POLL=100. The controller model shifts on `n8_pulse` rising and reloads on `n8_latch` high.
- Reset, then model pattern 8'b1111_0111 (Start pressed, active-low) -> latch high for cycles 0–7 of the frame, exactly 7 pulses of 4 cycles; at cycle 68 frame_valid=1 and buttons=8'h08, n8_start=1, others 0.
- Model presses Left+Up, giving buttons=8'h50 -> n8_left=1, n8_up=1. Release before the next frame -> next frame_valid gives buttons=8'h00. Buttons stay constant between strobes.
- Disconnected (n8_data=1 constantly) -> buttons=8'h00 each frame. n8_data=0 constantly -> 8'hFF.
- Measure frame_valid spacing over 5 frames -> exactly 100 cycles each. No latch or pulse activity in IDLE.
- Assert reset_n low mid-HIGH in frame 2 -> latch, pulse, buttons and frame_valid drop to 0 immediately without waiting for clk. After release, the first frame restarts after a full POLL period.
- Set POLL=60 (< 17P+2) with a tick during a frame -> tick ignored, the frame completes normally, and the next frame starts on the following IDLE tick.
